alu_cmd_queue: RTL and testbench
================================

// Module: alu_cmd_queue
// PURPOSE
//   Command buffer directly upstream of the ALU: accepts {A, B, opcode} commands on a
//   valid/ready handshake and stores them in a DEPTH-entry FIFO. Issues at most one command
//   per clock into registered ALU operand/opcode outputs. Honours a downstream stall.
//   Lets producers burst commands while the ALU consumes them at its own pace.
// PARAMETERS
//   DATA_W  32  operand width (A, B), signed two's complement, passed through unmodified
//   OP_W    3   opcode width, passed through unmodified
//   DEPTH   8   FIFO entries; power of two, >= 2
// PORTS
//   clk        in   1               clock; all state updates on posedge
//   rst        in   1               asynchronous reset, active-low
//   in_valid   in   1               producer command valid
//   in_ready   out  1               queue can accept (= !full && !flush)
//   in_a       in   DATA_W          operand A
//   in_b       in   DATA_W          operand B
//   in_opcode  in   OP_W            opcode
//   flush      in   1               synchronous discard of all queued commands
//   alu_stall  in   1               ALU cannot take a new command this cycle
//   alu_valid  out  1               alu_a/alu_b/alu_opcode hold a newly issued command
//   alu_a      out  DATA_W          registered operand A to ALU
//   alu_b      out  DATA_W          registered operand B to ALU
//   alu_opcode out  OP_W            registered opcode to ALU
//   count      out  $clog2(DEPTH)+1 entries currently stored
//   full       out  1               count == DEPTH
//   empty      out  1               count == 0
// BEHAVIOUR
//   - Reset (rst=0, async): wr/rd pointers=0, count=0, alu_valid=0, alu_a=alu_b=0,
//     alu_opcode=0. empty=1, full=0, in_ready=1 once rst releases.
//   - Push: at a posedge with in_valid && in_ready, write entry at wr_ptr; wr_ptr++ (wraps mod DEPTH).
//   - Pop: at a posedge with !empty && !alu_stall && !flush, load head into alu_* regs,
//     alu_valid=1 next cycle; rd_ptr++ (wraps mod DEPTH).
//   - No pop: alu_valid=0; alu_a/alu_b/alu_opcode hold their last values.
//   - Latency: command pushed at edge N is issued at edge N+1 at earliest (empty queue, no stall).
//     alu_valid is high in cycle N+1..N+2.
//   - Ordering strictly FIFO; no reordering, no data modification.
//   - Push+pop same edge: count unchanged. Pushing when full is impossible (in_ready=0).
//     Popping when empty is impossible.
//   - Full: in_ready=0 combinationally from count. A pop that edge frees a slot for the next cycle only.
//   - in_ready does not depend on alu_stall; no combinational path alu_stall -> in_ready.
//   - Empty-queue bypass: no bypass; a push into an empty queue never issues on the same edge.
//   - Flush (priority over push and pop): at the edge, pointers=0, count=0, alu_valid=0.
//     alu_* data holds. in_ready=0 while flush=1.
//   - alu_stall while alu_valid=1: the already-issued command is not repeated.
//     Stall only blocks the next pop.
//   - Reset asserted mid-burst: all queued commands are lost and outputs return to reset values
//     asynchronously.
// CONFIGURATION
//   ALU_CMD_QUEUE_STATS_EN defined: adds outputs
//     push_cnt  out 16             total accepted pushes, wraps at 2^16
//     pop_cnt   out 16             total issued commands, wraps at 2^16
//     hwm       out $clog2(DEPTH)+1 max count since reset, not cleared by flush
//   Reset values 0; flushed entries are not counted as pops.
//   ALU_CMD_QUEUE_STATS_EN undefined: these ports and registers do not exist; all other
//   behaviour is identical.
// TESTING
//   1. Reset, then push A=5,B=-3,op=3'd0 with stall=0 -> alu_valid 1 cycle, alu_a=5,
//      alu_b=-3, alu_opcode=0. Issue edge is 1 after the push edge; empty=1 afterwards.
//   2. alu_stall=1, push 8 cmds (A=0..7) -> full=1, in_ready=0, count=8.
//      9th in_valid is held off. Release stall -> 8 consecutive alu_valid pulses, A=0..7 in order.
//   3. Sustained push+pop each cycle at count=3 for 20 cycles -> count stays 3.
//      Pointers wrap past DEPTH with no loss or duplication.
//   4. count=5, assert flush with in_valid=1 -> next cycle count=0, empty=1, alu_valid=0.
//      Flush-cycle command not stored.
//   5. Async rst=0 mid-burst (count=4, alu_valid=1) -> immediately alu_valid=0, alu_*=0,
//      count=0, with no clock edge required.
//   6. With ALU_CMD_QUEUE_STATS_EN: 10 pushes, 6 pops, flush -> push_cnt=10, pop_cnt=6,
//      hwm = peak count observed.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of the ALU: valid/ready intake, one registered issue per clock, stall-aware.
// Optional statistics counters are built when ALU_CMD_QUEUE_STATS_EN is defined.
module alu_cmd_queue #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [OP_W-1:0]          in_opcode,
  input  logic                     flush,
  input  logic                     alu_stall,
  output logic                     alu_valid,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OP_W-1:0]          alu_opcode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef ALU_CMD_QUEUE_STATS_EN
  ,
  output logic [15:0]              push_cnt,
  output logic [15:0]              pop_cnt,
  output logic [$clog2(DEPTH):0]   hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATA_W + OP_W;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              alu_valid_q, alu_valid_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;

  logic              full_w;
  logic              empty_w;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // in_ready depends only on occupancy and flush, never on alu_stall
  assign in_ready = !full_w && !flush;
  assign push     = in_valid && !full_w && !flush;
  assign pop      = !empty_w && !alu_stall && !flush;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    alu_valid_d = pop;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        alu_a_d  = head[EW-1 -: DATA_W];
        alu_b_d  = head[OP_W +: DATA_W];
        alu_op_d = head[OP_W-1:0];
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b, in_opcode};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_valid_q <= alu_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign alu_valid  = alu_valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign count      = count_q;
  assign full       = full_w;
  assign empty      = empty_w;

`ifdef ALU_CMD_QUEUE_STATS_EN
  logic [15:0]   push_cnt_q, push_cnt_d;
  logic [15:0]   pop_cnt_q, pop_cnt_d;
  logic [CW-1:0] hwm_q, hwm_d;

  // Peak tracks the post-edge occupancy so it matches count as seen next cycle
  always_comb begin
    push_cnt_d = push ? push_cnt_q + 16'd1 : push_cnt_q;
    pop_cnt_d  = pop  ? pop_cnt_q + 16'd1  : pop_cnt_q;
    hwm_d      = (count_d > hwm_q) ? count_d : hwm_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
      hwm_q      <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      hwm_q      <= hwm_d;
    end
  end

  assign push_cnt = push_cnt_q;
  assign pop_cnt  = pop_cnt_q;
  assign hwm      = hwm_q;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: directed vector table plus a queue-based reference model.
// Stats checks are compiled in when ALU_CMD_QUEUE_STATS_EN is defined.
module tb_alu_cmd_queue;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [OW-1:0] in_opcode = '0;
  logic          flush = 1'b0;
  logic          alu_stall = 1'b0;
  logic          alu_valid;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [OW-1:0] alu_opcode;
  logic [3:0]    count;
  logic          full;
  logic          empty;
`ifdef ALU_CMD_QUEUE_STATS_EN
  logic [15:0]   push_cnt;
  logic [15:0]   pop_cnt;
  logic [3:0]    hwm;
`endif

  always #5 clk = ~clk;

  alu_cmd_queue #(.DATA_W(DW), .OP_W(OW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .flush(flush),
    .alu_stall(alu_stall), .alu_valid(alu_valid), .alu_a(alu_a),
    .alu_b(alu_b), .alu_opcode(alu_opcode), .count(count), .full(full),
    .empty(empty)
`ifdef ALU_CMD_QUEUE_STATS_EN
    , .push_cnt(push_cnt), .pop_cnt(pop_cnt), .hwm(hwm)
`endif
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
  } cmd_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic          fl;
    logic          st;
    int            e_cnt;
    logic          e_valid;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
    logic          e_empty;
  } vec_t;

  cmd_t          sb_q[$];
  int            m_cnt;
  logic          m_valid;
  logic [DW-1:0] m_a, m_b;
  logic [OW-1:0] m_op;
  int            m_push, m_pop, m_hwm;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_cnt = 0; m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0;
    m_push = 0; m_pop = 0; m_hwm = 0;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [OW-1:0] op, input logic fl, input logic st);
    in_valid = v; in_a = a; in_b = b; in_opcode = op; flush = fl; alu_stall = st;
  endtask

  // One clock: check in_ready, advance the reference model at the edge, compare at negedge.
  task automatic step();
    logic m_ready, do_push, do_pop;
    cmd_t c;
    #1;
    m_ready = (m_cnt != D) && !flush;
    check("in_ready", 64'(in_ready), 64'(m_ready));
    @(posedge clk);
    do_push = in_valid && m_ready;
    do_pop  = (m_cnt != 0) && !alu_stall && !flush;
    if (flush) begin
      sb_q.delete();
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (do_pop) begin
        c = sb_q.pop_front();
        m_a = c.a; m_b = c.b; m_op = c.op;
        m_valid = 1'b1;
        m_pop++;
      end
      if (do_push) begin
        c.a = in_a; c.b = in_b; c.op = in_opcode;
        sb_q.push_back(c);
        m_push++;
      end
    end
    m_cnt = sb_q.size();
    if (m_cnt > m_hwm) m_hwm = m_cnt;
    @(negedge clk);
    check("alu_valid", 64'(alu_valid), 64'(m_valid));
    check("alu_a", 64'(alu_a), 64'(m_a));
    check("alu_b", 64'(alu_b), 64'(m_b));
    check("alu_opcode", 64'(alu_opcode), 64'(m_op));
    check("count", 64'(count), 64'(m_cnt));
    check("empty", 64'(empty), 64'(m_cnt == 0));
    check("full", 64'(full), 64'(m_cnt == D));
`ifdef ALU_CMD_QUEUE_STATS_EN
    check("push_cnt", 64'(push_cnt), 64'(m_push & 16'hFFFF));
    check("pop_cnt", 64'(pop_cnt), 64'(m_pop & 16'hFFFF));
    check("hwm", 64'(hwm), 64'(m_hwm));
`endif
  endtask

  vec_t vt[9];
  int   pulses;
  int   nexp;

  initial begin
    // v, a, b, op, flush, stall | count, valid, alu_a, alu_b, empty
    vt[0] = '{1'b1, 32'd5,  32'hFFFF_FFFD, 3'd0, 1'b0, 1'b0, 1, 1'b0, 32'd0, 32'd0,         1'b0};
    vt[1] = '{1'b0, 32'd0,  32'd0,         3'd0, 1'b0, 1'b0, 0, 1'b1, 32'd5, 32'hFFFF_FFFD, 1'b1};
    vt[2] = '{1'b0, 32'd0,  32'd0,         3'd0, 1'b0, 1'b0, 0, 1'b0, 32'd5, 32'hFFFF_FFFD, 1'b1};
    vt[3] = '{1'b1, 32'd9,  32'd1,         3'd5, 1'b0, 1'b1, 1, 1'b0, 32'd5, 32'hFFFF_FFFD, 1'b0};
    vt[4] = '{1'b1, 32'd10, 32'd2,         3'd6, 1'b0, 1'b1, 2, 1'b0, 32'd5, 32'hFFFF_FFFD, 1'b0};
    vt[5] = '{1'b0, 32'd0,  32'd0,         3'd0, 1'b0, 1'b0, 1, 1'b1, 32'd9, 32'd1,         1'b0};
    vt[6] = '{1'b0, 32'd0,  32'd0,         3'd0, 1'b0, 1'b1, 1, 1'b0, 32'd9, 32'd1,         1'b0};
    vt[7] = '{1'b1, 32'd11, 32'd3,         3'd7, 1'b1, 1'b0, 0, 1'b0, 32'd9, 32'd1,         1'b1};
    vt[8] = '{1'b0, 32'd0,  32'd0,         3'd0, 1'b0, 1'b0, 0, 1'b0, 32'd9, 32'd1,         1'b1};

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_alu_valid", 64'(alu_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    @(negedge clk);

    // Directed table: single issue, stall hold, flush drop
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].v, vt[i].a, vt[i].b, vt[i].op, vt[i].fl, vt[i].st);
      step();
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
      check($sformatf("vec%0d_valid", i), 64'(alu_valid), 64'(vt[i].e_valid));
      check($sformatf("vec%0d_alu_a", i), 64'(alu_a), 64'(vt[i].e_a));
      check($sformatf("vec%0d_alu_b", i), 64'(alu_b), 64'(vt[i].e_b));
      check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vt[i].e_empty));
    end

    // Fill to full under stall, hold off a ninth, then drain in order
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 32'(i * 3), 3'(i), 1'b0, 1'b1);
      step();
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_count", 64'(count), 64'd8);
    drive(1'b1, 32'd99, 32'd99, 3'd1, 1'b0, 1'b1);
    step();
    check("ninth_held_count", 64'(count), 64'd8);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    pulses = 0;
    nexp = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (alu_valid) begin
        check("drain_order", 64'(alu_a), 64'(nexp));
        nexp++;
        pulses++;
      end
    end
    check("drain_pulses", 64'(pulses), 64'd8);

    // Steady push+pop at occupancy 3; pointers wrap several times
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(100 + i), 32'(i), 3'(i), 1'b0, 1'b1);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(200 + i), 32'(50 + i), 3'(i), 1'b0, 1'b0);
      step();
      check("sustain_count", 64'(count), 64'd3);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (5) step();

    // Flush at count 5 with a concurrent push
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(300 + i), 32'd7, 3'd2, 1'b0, 1'b1);
      step();
    end
    drive(1'b1, 32'd400, 32'd8, 3'd3, 1'b1, 1'b0);
    step();
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_valid", 64'(alu_valid), 64'd0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    check("post_flush_no_issue", 64'(alu_valid), 64'd0);

    // Asynchronous reset mid-burst, between clock edges
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(500 + i), 32'd9, 3'd4, 1'b0, 1'b1);
      step();
    end
    drive(1'b1, 32'd600, 32'd10, 3'd5, 1'b0, 1'b0);
    step();
    check("pre_rst_count", 64'(count), 64'd4);
    check("pre_rst_valid", 64'(alu_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(alu_valid), 64'd0);
    check("arst_alu_a", 64'(alu_a), 64'd0);
    check("arst_alu_b", 64'(alu_b), 64'd0);
    check("arst_opcode", 64'(alu_opcode), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step();

    // 10 pushes, 6 pops, then flush
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'(700 + i), 32'd1, 3'd6, 1'b0, 1'b1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(710 + i), 32'd2, 3'd7, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (3) step();
    check("stat_seq_count", 64'(count), 64'd4);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
`ifdef ALU_CMD_QUEUE_STATS_EN
    check("stat_push_cnt", 64'(push_cnt), 64'd10);
    check("stat_pop_cnt", 64'(pop_cnt), 64'd6);
    check("stat_hwm", 64'(hwm), 64'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
